// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// RISC-V opcode constants, opcode classes, alu_op / writeback-select codes
// and trap causes.
package multicycle_controller_pkg;

  localparam int unsigned WAIT_W = 8;  // holds TIMEOUT_CYCLES up to 255

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_I_ALU   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_MEM = 1;
  localparam int unsigned WB_PC4 = 2;
  localparam int unsigned WB_IMM = 3;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'b10;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'b11;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode classifier.
// Ports: opcode_i - instruction[6:0]; class_o - decoded opcode class.
module opcode_classifier
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_e  class_o
);

  always_comb begin
    case (opcode_i)
      OPC_R:      class_o = CLS_R;
      OPC_I_ALU:  class_o = CLS_I_ALU;
      OPC_LOAD:   class_o = CLS_LOAD;
      OPC_STORE:  class_o = CLS_STORE;
      OPC_BRANCH: class_o = CLS_BRANCH;
      OPC_JAL:    class_o = CLS_JAL;
      OPC_JALR:   class_o = CLS_JALR;
      OPC_LUI:    class_o = CLS_LUI;
      OPC_AUIPC:  class_o = CLS_AUIPC;
      default:    class_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with
// memory-ready timeouts, stall freeze and a retired-instruction counter.
// Inputs : clock, reset_n, opcode, imem_ready, dmem_ready, stall, trap_clear
// Outputs: datapath enables, alu_op, three mux selects, trap/trap_cause,
//          retired count.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned MUX_SEL_W      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned RETIRE_W       = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  input  logic                 stall,
  input  logic                 trap_clear,
  output logic                 imem_re,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic                 reg_file_write,
  output logic                 branch_instruction,
  output logic [1:0]           alu_op,
  output logic [MUX_SEL_W-1:0] select_mux_1,
  output logic [MUX_SEL_W-1:0] select_mux_2,
  output logic [MUX_SEL_W-1:0] select_mux_4,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [RETIRE_W-1:0]  retired
);

  state_e              state_q, state_d;
  op_class_e           class_q, class_d, dec_class;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic [1:0]          cause_q, cause_d;
  logic                wait_last, retire;

  opcode_classifier u_classifier (
    .opcode_i (opcode),
    .class_o  (dec_class)
  );

  // Last allowed wait cycle; a ready seen in this cycle still wins.
  assign wait_last = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  // State and counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_FETCH;
      class_q   <= CLS_R;
      wait_q    <= '0;
      retired_q <= '0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      cause_q   <= cause_d;
    end
  end

  // Next state, wait counter, retire and trap cause; stall freezes everything
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    cause_d   = cause_q;
    retire    = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            state_d = ST_DECODE;
          end else if (wait_last) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_IMEM_TO;
          end
        end
        ST_DECODE: begin
          class_d = dec_class;
          if (dec_class == CLS_ILLEGAL) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (class_q)
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_BRANCH: begin
              state_d = ST_FETCH;
              retire  = 1'b1;
            end
            default: state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (class_q == CLS_STORE) begin
              state_d = ST_FETCH;
              retire  = 1'b1;
            end else begin
              state_d = ST_WB;
            end
          end else if (wait_last) begin
            state_d = ST_TRAP;
            cause_d = CAUSE_DMEM_TO;
          end
        end
        ST_WB: begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
        ST_TRAP: begin
          if (trap_clear) begin
            state_d = ST_FETCH;
            cause_d = CAUSE_NONE;
          end
        end
        default: state_d = ST_FETCH;
      endcase
      // Counter restarts on any state change and counts only while waiting on a ready
      if (state_d != state_q) begin
        wait_d = '0;
      end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
        wait_d = wait_q + WAIT_W'(1);
      end
      if (retire) begin
        retired_d = retired_q + RETIRE_W'(1);
      end
    end
  end

  // Moore output decode from state and latched class
  always_comb begin
    imem_re            = 1'b0;
    ir_we              = 1'b0;
    pc_we              = 1'b0;
    mem_re             = 1'b0;
    mem_we             = 1'b0;
    reg_file_write     = 1'b0;
    branch_instruction = 1'b0;
    alu_op             = ALU_ADD;
    select_mux_1       = '0;
    select_mux_2       = '0;
    select_mux_4       = '0;
    trap               = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_re = 1'b1;
        ir_we   = imem_ready;
      end
      ST_EXEC: begin
        case (class_q)
          CLS_R: alu_op = ALU_FUNCT;
          CLS_I_ALU: begin
            alu_op       = ALU_FUNCT;
            select_mux_2 = MUX_SEL_W'(1);
          end
          CLS_LOAD, CLS_STORE: begin
            alu_op       = ALU_ADD;
            select_mux_2 = MUX_SEL_W'(1);
          end
          CLS_BRANCH: begin
            alu_op             = ALU_SUB;
            branch_instruction = 1'b1;
            pc_we              = 1'b1;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      ST_MEM: begin
        mem_re = (class_q == CLS_LOAD);
        mem_we = (class_q == CLS_STORE);
        // PC advances only on the completing cycle of a store, never per wait cycle
        pc_we  = (class_q == CLS_STORE) && dmem_ready;
      end
      ST_WB: begin
        reg_file_write = 1'b1;
        pc_we          = 1'b1;
        case (class_q)
          CLS_LOAD:          select_mux_4 = MUX_SEL_W'(WB_MEM);
          CLS_JAL, CLS_JALR: select_mux_4 = MUX_SEL_W'(WB_PC4);
          CLS_LUI:           select_mux_4 = MUX_SEL_W'(WB_IMM);
          default:           select_mux_4 = MUX_SEL_W'(WB_ALU);
        endcase
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
    // Operand A comes from the PC for PC-relative classes while an instruction is in flight
    if ((state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) &&
        (class_q == CLS_AUIPC || class_q == CLS_JAL || class_q == CLS_BRANCH)) begin
      select_mux_1 = MUX_SEL_W'(1);
    end
    // Enables drop immediately under stall or while reset is held
    if (stall || !reset_n) begin
      imem_re        = 1'b0;
      ir_we          = 1'b0;
      pc_we          = 1'b0;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      reg_file_write = 1'b0;
    end
  end

  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller with
// TIMEOUT_CYCLES = 4 and RETIRE_W = 4; inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic       imem_ready, dmem_ready, stall, trap_clear;
  logic       imem_re, ir_we, pc_we, mem_re, mem_we, reg_file_write, branch_instruction;
  logic [1:0] alu_op, sel1, sel2, sel4, trap_cause;
  logic       trap;
  logic [3:0] retired;

  always #5 clk = ~clk;

  multicycle_controller #(
    .MUX_SEL_W(2), .TIMEOUT_CYCLES(4), .RETIRE_W(4)
  ) dut (
    .clock(clk), .reset_n(reset_n), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .stall(stall), .trap_clear(trap_clear),
    .imem_re(imem_re), .ir_we(ir_we), .pc_we(pc_we), .mem_re(mem_re), .mem_we(mem_we),
    .reg_file_write(reg_file_write), .branch_instruction(branch_instruction),
    .alu_op(alu_op), .select_mux_1(sel1), .select_mux_2(sel2), .select_mux_4(sel4),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  // en = {imem_re, ir_we, pc_we, mem_re, mem_we, reg_file_write, branch_instruction}
  typedef struct packed {
    logic [6:0] en;
    logic [1:0] alu, s1, s2, s4;
    logic       tr;
    logic [1:0] cause;
    logic [3:0] ret;
  } obs_t;

  typedef struct {
    logic [6:0] opc;
    logic       ir, dr, st, tc;
    state_e     s;
    obs_t       o;
  } vec_t;

  localparam logic [6:0] E_NONE = 7'b0000000;
  localparam logic [6:0] E_F    = 7'b1000000;
  localparam logic [6:0] E_FIR  = 7'b1100000;
  localparam logic [6:0] E_MRE  = 7'b0001000;
  localparam logic [6:0] E_MWE  = 7'b0000100;
  localparam logic [6:0] E_SDN  = 7'b0010100;
  localparam logic [6:0] E_WB   = 7'b0010010;
  localparam logic [6:0] E_BR   = 7'b0010001;
  localparam logic [6:0] ILL    = 7'b1111111;

  int checks = 0;
  int passed = 0;
  vec_t vecs[$];

  function automatic obs_t sample();
    return obs_t'({imem_re, ir_we, pc_we, mem_re, mem_we, reg_file_write, branch_instruction,
                   alu_op, sel1, sel2, sel4, trap, trap_cause, retired});
  endfunction

  function automatic vec_t mk(logic [6:0] opc, logic ir, logic dr, logic st, logic tc,
                              state_e s, logic [6:0] en, logic [1:0] alu, logic [1:0] s1,
                              logic [1:0] s2, logic [1:0] s4, logic tr, logic [1:0] cause,
                              logic [3:0] ret);
    vec_t v;
    v.opc = opc; v.ir = ir; v.dr = dr; v.st = st; v.tc = tc; v.s = s;
    v.o = obs_t'({en, alu, s1, s2, s4, tr, cause, ret});
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [6:0] opc, input logic ir, input logic dr,
                       input logic st, input logic tc);
    @(negedge clk);
    opcode = opc; imem_ready = ir; dmem_ready = dr; stall = st; trap_clear = tc;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; opcode = OPC_R; imem_ready = 1'b0; dmem_ready = 1'b0;
    stall = 1'b0; trap_clear = 1'b0;

    // opc ir dr st tc state en alu s1 s2 s4 trap cause retired
    // LOAD: ready on first fetch cycle, dmem_ready on 4th MEM cycle (limit cycle)
    vecs.push_back(mk(OPC_LOAD, 1,0,0,0, ST_FETCH,  E_FIR,  0,0,0,0, 0,0,0));
    vecs.push_back(mk(OPC_LOAD, 0,0,0,0, ST_DECODE, E_NONE, 0,0,0,0, 0,0,0));
    vecs.push_back(mk(OPC_LOAD, 0,0,0,0, ST_EXEC,   E_NONE, 0,0,1,0, 0,0,0));
    vecs.push_back(mk(OPC_LOAD, 0,0,0,0, ST_MEM,    E_MRE,  0,0,0,0, 0,0,0));
    vecs.push_back(mk(OPC_LOAD, 0,0,0,0, ST_MEM,    E_MRE,  0,0,0,0, 0,0,0));
    vecs.push_back(mk(OPC_LOAD, 0,0,0,0, ST_MEM,    E_MRE,  0,0,0,0, 0,0,0));
    vecs.push_back(mk(OPC_LOAD, 0,1,0,0, ST_MEM,    E_MRE,  0,0,0,0, 0,0,0));
    vecs.push_back(mk(OPC_LOAD, 0,0,0,0, ST_WB,     E_WB,   0,0,0,1, 0,0,0));
    // R-type with imem_ready only on the limit fetch cycle
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,1));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,1));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,1));
    vecs.push_back(mk(OPC_R,    1,0,0,0, ST_FETCH,  E_FIR,  0,0,0,0, 0,0,1));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_DECODE, E_NONE, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_EXEC,   E_NONE, 2,0,0,0, 0,0,1));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_WB,     E_WB,   0,0,0,0, 0,0,1));
    // BRANCH retires from EXEC
    vecs.push_back(mk(OPC_BRANCH,1,0,0,0, ST_FETCH, E_FIR,  0,0,0,0, 0,0,2));
    vecs.push_back(mk(OPC_BRANCH,0,0,0,0, ST_DECODE,E_NONE, 0,0,0,0, 0,0,2));
    vecs.push_back(mk(OPC_BRANCH,0,0,0,0, ST_EXEC,  E_BR,   1,1,0,0, 0,0,2));
    // STORE with stall overriding dmem_ready and trap_clear
    vecs.push_back(mk(OPC_STORE,1,0,0,0, ST_FETCH,  E_FIR,  0,0,0,0, 0,0,3));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_DECODE, E_NONE, 0,0,0,0, 0,0,3));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_EXEC,   E_NONE, 0,0,1,0, 0,0,3));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_MEM,    E_MWE,  0,0,0,0, 0,0,3));
    vecs.push_back(mk(OPC_STORE,0,1,1,0, ST_MEM,    E_NONE, 0,0,0,0, 0,0,3));
    vecs.push_back(mk(OPC_STORE,0,1,1,1, ST_MEM,    E_NONE, 0,0,0,0, 0,0,3));
    vecs.push_back(mk(OPC_STORE,0,1,0,0, ST_MEM,    E_SDN,  0,0,0,0, 0,0,3));
    // Illegal opcode -> TRAP cause 01; stall blocks trap_clear once
    vecs.push_back(mk(ILL,      1,0,0,0, ST_FETCH,  E_FIR,  0,0,0,0, 0,0,4));
    vecs.push_back(mk(ILL,      0,0,0,0, ST_DECODE, E_NONE, 0,0,0,0, 0,0,4));
    vecs.push_back(mk(ILL,      0,0,0,0, ST_TRAP,   E_NONE, 0,0,0,0, 1,1,4));
    vecs.push_back(mk(ILL,      0,0,1,1, ST_TRAP,   E_NONE, 0,0,0,0, 1,1,4));
    vecs.push_back(mk(ILL,      0,0,0,1, ST_TRAP,   E_NONE, 0,0,0,0, 1,1,4));
    // Fetch timeout after 4 cycles -> cause 10
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_R,    0,0,0,1, ST_TRAP,   E_NONE, 0,0,0,0, 1,2,4));
    // STORE dmem timeout after 4 MEM cycles -> cause 11, mem_we low in TRAP
    vecs.push_back(mk(OPC_STORE,1,0,0,0, ST_FETCH,  E_FIR,  0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_DECODE, E_NONE, 0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_EXEC,   E_NONE, 0,0,1,0, 0,0,4));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_MEM,    E_MWE,  0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_MEM,    E_MWE,  0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_MEM,    E_MWE,  0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_STORE,0,0,0,0, ST_MEM,    E_MWE,  0,0,0,0, 0,0,4));
    vecs.push_back(mk(OPC_STORE,0,0,0,1, ST_TRAP,   E_NONE, 0,0,0,0, 1,3,4));
    vecs.push_back(mk(OPC_R,    0,0,0,0, ST_FETCH,  E_F,    0,0,0,0, 0,0,4));

    // Reset values while reset_n is held low
    @(negedge clk); #1;
    chk("reset outputs", 32'(sample()), 32'd0);
    chk("reset state", 32'(dut.state_q), 32'(ST_FETCH));
    @(negedge clk); reset_n = 1'b1; #1;
    chk("release imem_re", 32'(imem_re), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].opc, vecs[i].ir, vecs[i].dr, vecs[i].st, vecs[i].tc);
      chk($sformatf("vec%0d state", i), 32'(dut.state_q), 32'(vecs[i].s));
      chk($sformatf("vec%0d outputs", i), 32'(sample()), 32'(vecs[i].o));
    end

    // LOAD stalled 5 cycles in MEM: everything frozen, then resumes
    drive(OPC_LOAD, 1, 0, 0, 0);
    drive(OPC_LOAD, 0, 0, 0, 0);
    drive(OPC_LOAD, 0, 0, 0, 0);
    drive(OPC_LOAD, 0, 0, 0, 0);
    chk("stall pre mem_re", 32'(mem_re), 32'd1);
    for (int k = 0; k < 5; k++) begin
      drive(OPC_LOAD, 0, 0, 1, 0);
      chk($sformatf("stall%0d state", k), 32'(dut.state_q), 32'(ST_MEM));
      chk($sformatf("stall%0d mem_re", k), 32'(mem_re), 32'd0);
      chk($sformatf("stall%0d wait", k), 32'(dut.wait_q), 32'd1);
      chk($sformatf("stall%0d retired", k), 32'(retired), 32'd4);
    end
    drive(OPC_LOAD, 0, 0, 0, 0);
    chk("resume mem_re", 32'(mem_re), 32'd1);
    drive(OPC_LOAD, 0, 1, 0, 0);
    chk("resume ready state", 32'(dut.state_q), 32'(ST_MEM));
    drive(OPC_LOAD, 0, 0, 0, 0);
    chk("resume wb", 32'({dut.state_q == ST_WB, reg_file_write, sel4}), 32'b1101);
    drive(OPC_R, 0, 0, 0, 0);
    chk("resume retired", 32'(retired), 32'd5);

    // Asynchronous reset in the middle of a BRANCH EXEC cycle
    drive(OPC_BRANCH, 1, 0, 0, 0);
    drive(OPC_BRANCH, 0, 0, 0, 0);
    drive(OPC_BRANCH, 0, 0, 0, 0);
    chk("branch exec", 32'(branch_instruction), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async reset outputs", 32'(sample()), 32'd0);
    chk("async reset state", 32'(dut.state_q), 32'(ST_FETCH));
    @(negedge clk); reset_n = 1'b1; #1;
    chk("post reset fetch", 32'({imem_re, retired}), 32'h10);

    // 17 R-type instructions wrap the 4-bit retired counter to 1
    for (int k = 0; k < 17; k++) begin
      drive(OPC_R, 1, 0, 0, 0);
      drive(OPC_R, 0, 0, 0, 0);
      drive(OPC_R, 0, 0, 0, 0);
      drive(OPC_R, 0, 0, 0, 0);
    end
    drive(OPC_R, 0, 0, 0, 0);
    chk("wrap state", 32'(dut.state_q), 32'(ST_FETCH));
    chk("wrap retired", 32'(retired), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
